phy_rx_serial_to_parallel: RTL

- Receive-side counterpart of the phy_tx serializer.
- Takes the 1-bit MSB-first serial stream on clk_32f and finds word alignment by locking onto consecutive COM (8'hBC) words.
- Once locked, it delivers 8-bit words to the phy_rx lane demux, with a valid strobe for payload bytes and an idle flag for IDLE (8'h7C) words.

---
 rtl/phy_rx_serial_to_parallel.sv | 119 +++++++++++
 1 files changed

// File: rtl/phy_rx_serial_to_parallel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | phy_rx_serial_to_parallel: comma-aligned 1->8 deserializer for phy_rx      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module phy_rx_serial_to_parallel #(
  parameter logic [7:0]  COM_WORD      = 8'hBC,
  parameter logic [7:0]  IDLE_WORD     = 8'h7C,
  parameter int unsigned BC_LOCK_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       idle_out,
  output logic       active
);

  localparam logic [1:0] c_search = 2'd0;
  localparam logic [1:0] c_sync   = 2'd1;
  localparam logic [1:0] c_active = 2'd2;

  localparam logic [3:0] c_lock_last = 4'(BC_LOCK_COUNT - 1);

  logic [7:0] r_sr;
  logic [2:0] r_bit_cnt;
  logic [3:0] r_bc_cnt;
  logic [1:0] r_state;
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_idle;
  logic       r_active;

  logic w_is_com;
  logic w_is_idle;
  logic w_boundary;

  assign w_is_com   = (r_sr == COM_WORD);
  assign w_is_idle  = (r_sr == IDLE_WORD);
  // Only meaningful in SYNC/ACTIVE; SEARCH keeps the counter parked at 0.
  assign w_boundary = (r_bit_cnt == 3'd0);

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      r_sr      <= 8'h00;
      r_bit_cnt <= 3'd0;
      r_bc_cnt  <= 4'd0;
      r_state   <= c_search;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_idle    <= 1'b0;
      r_active  <= 1'b0;
    end else begin
      r_sr    <= {r_sr[6:0], data_in};
      r_valid <= 1'b0;
      r_idle  <= 1'b0;

      case (r_state)
        c_search: begin
          if (w_is_com) begin
            r_bit_cnt <= 3'd1;
            r_bc_cnt  <= 4'd1;
            if (BC_LOCK_COUNT == 1) begin
              r_state  <= c_active;
              r_active <= 1'b1;
            end else begin
              r_state <= c_sync;
            end
          end else begin
            r_bit_cnt <= 3'd0;
          end
        end

        c_sync: begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (w_boundary) begin
            if (w_is_com) begin
              if (r_bc_cnt == c_lock_last) begin
                r_state  <= c_active;
                r_active <= 1'b1;
              end else begin
                r_bc_cnt <= r_bc_cnt + 4'd1;
              end
            end else begin
              r_state   <= c_search;
              r_bc_cnt  <= 4'd0;
              r_bit_cnt <= 3'd0;
            end
          end
        end

        c_active: begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          // Lock is sticky; only reset_L leaves ACTIVE.
          if (w_boundary) begin
            r_data  <= r_sr;
            r_valid <= !w_is_com && !w_is_idle;
            r_idle  <= w_is_idle;
          end
        end

        default: begin
          r_state   <= c_search;
          r_bit_cnt <= 3'd0;
          r_bc_cnt  <= 4'd0;
          r_active  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign idle_out  = r_idle;
  assign active    = r_active;

endmodule
`default_nettype wire
